// File: rtl/regfile_rename_if.sv
// Decoder/ROB/operand-read bundle for the renaming register file.
// The master side drives rename, commit, flush and read indices; the slave side is the register file.
interface regfile_rename_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ROB_ID_W   = 4
);
  logic                  flush_input;
  logic                  from_decoder_write_enabled;
  logic [REG_ADDR_W-1:0] from_decoder_reg_id;
  logic [ROB_ID_W-1:0]   from_decoder_rob_id;
  logic                  from_rob_write_enabled;
  logic [REG_ADDR_W-1:0] from_rob_reg_id;
  logic [ROB_ID_W-1:0]   from_rob_rob_id;
  logic [XLEN-1:0]       from_rob_data;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic                  rs1_busy;
  logic [ROB_ID_W-1:0]   rs1_tag;
  logic [XLEN-1:0]       rs1_data;
  logic                  rs2_busy;
  logic [ROB_ID_W-1:0]   rs2_tag;
  logic [XLEN-1:0]       rs2_data;
  logic [REG_ADDR_W:0]   busy_count;

  modport master (
    output flush_input, from_decoder_write_enabled, from_decoder_reg_id, from_decoder_rob_id,
    output from_rob_write_enabled, from_rob_reg_id, from_rob_rob_id, from_rob_data,
    output rs1_id, rs2_id,
    input  rs1_busy, rs1_tag, rs1_data, rs2_busy, rs2_tag, rs2_data, busy_count
  );

  modport slave (
    input  flush_input, from_decoder_write_enabled, from_decoder_reg_id, from_decoder_rob_id,
    input  from_rob_write_enabled, from_rob_reg_id, from_rob_rob_id, from_rob_data,
    input  rs1_id, rs2_id,
    output rs1_busy, rs1_tag, rs1_data, rs2_busy, rs2_tag, rs2_data, busy_count
  );
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy/ROB-tag rename state,
// tag-matched commit clearing, commit bypass on two read ports and a busy counter.
module regfile_rename #(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ROB_ID_W   = 4
) (
  input logic              clk_in,
  input logic              rst_in,
  regfile_rename_if.slave  bus
);
  localparam int DEPTH = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W:0] REG_LIMIT = (REG_ADDR_W + 1)'(REG_COUNT);

  logic [XLEN-1:0]     r_data [DEPTH];
  logic [ROB_ID_W-1:0] r_tag  [DEPTH];
  logic [DEPTH-1:0]    r_busy;
  logic [REG_ADDR_W:0] r_busy_count;

  logic                w_ren_valid;
  logic                w_cmt_valid;
  logic                w_cmt_match;
  logic                w_clear;
  logic [REG_ADDR_W:0] w_count_inc;
  logic [REG_ADDR_W:0] w_count_dec;

  // x0 and indices beyond REG_COUNT never hold state.
  function automatic logic f_legal(input logic [REG_ADDR_W-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < REG_LIMIT);
  endfunction

  always_comb begin
    w_ren_valid = bus.from_decoder_write_enabled && !bus.flush_input
                  && f_legal(bus.from_decoder_reg_id);
    w_cmt_valid = bus.from_rob_write_enabled && f_legal(bus.from_rob_reg_id);
    w_cmt_match = w_cmt_valid && r_busy[bus.from_rob_reg_id]
                  && (r_tag[bus.from_rob_reg_id] == bus.from_rob_rob_id);
    // A same-cycle rename of the committing register keeps it busy under the new tag.
    w_clear     = w_cmt_match
                  && !(w_ren_valid && (bus.from_decoder_reg_id == bus.from_rob_reg_id));
    w_count_inc = {{REG_ADDR_W{1'b0}}, w_ren_valid && !r_busy[bus.from_decoder_reg_id]};
    w_count_dec = {{REG_ADDR_W{1'b0}}, w_clear};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_cmt_valid) begin
        r_data[bus.from_rob_reg_id] <= bus.from_rob_data;
      end
      if (bus.flush_input) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_tag[i] <= '0;
        end
        r_busy       <= '0;
        r_busy_count <= '0;
      end else begin
        if (w_ren_valid) begin
          r_busy[bus.from_decoder_reg_id] <= 1'b1;
          r_tag[bus.from_decoder_reg_id]  <= bus.from_decoder_rob_id;
        end
        if (w_clear) begin
          r_busy[bus.from_rob_reg_id] <= 1'b0;
        end
        r_busy_count <= r_busy_count + w_count_inc - w_count_dec;
      end
    end
  end

  logic [REG_ADDR_W-1:0] w_rd_id   [2];
  logic                  w_rd_busy [2];
  logic [ROB_ID_W-1:0]   w_rd_tag  [2];
  logic [XLEN-1:0]       w_rd_data [2];

  assign w_rd_id[0] = bus.rs1_id;
  assign w_rd_id[1] = bus.rs2_id;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      logic w_legal;
      logic w_bypass;
      always_comb begin
        w_legal  = f_legal(w_rd_id[gi]);
        w_bypass = bus.from_rob_write_enabled && w_legal
                   && (w_rd_id[gi] == bus.from_rob_reg_id)
                   && r_busy[w_rd_id[gi]]
                   && (r_tag[w_rd_id[gi]] == bus.from_rob_rob_id);
        w_rd_busy[gi] = 1'b0;
        w_rd_tag[gi]  = '0;
        w_rd_data[gi] = '0;
        if (w_legal) begin
          w_rd_tag[gi] = r_tag[w_rd_id[gi]];
          if (w_bypass) begin
            w_rd_data[gi] = bus.from_rob_data;
          end else begin
            w_rd_busy[gi] = r_busy[w_rd_id[gi]];
            w_rd_data[gi] = r_data[w_rd_id[gi]];
          end
        end
      end
    end
  endgenerate

  assign bus.rs1_busy   = w_rd_busy[0];
  assign bus.rs1_tag    = w_rd_tag[0];
  assign bus.rs1_data   = w_rd_data[0];
  assign bus.rs2_busy   = w_rd_busy[1];
  assign bus.rs2_tag    = w_rd_tag[1];
  assign bus.rs2_data   = w_rd_data[1];
  assign bus.busy_count = r_busy_count;
endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
Parametrised architectural register file with per-register rename tracking (busy bit plus ROB tag), sitting between the decoder (rename and operand read) and the ROB (in-order commit).
- Generalises the original register file:
  - explicit busy bit, so ROB id 0 is a legal tag;
  - tag-matched commit clearing;
  - two operand read ports with same-cycle commit bypass;
  - hardwired x0;
  - a busy-register counter.

Parameters:
XLEN, 32, data width in bits
REG_COUNT, 32, number of architectural registers (at most 2^REG_ADDR_W)
REG_ADDR_W, 5, register index width
ROB_ID_W, 4, ROB tag width

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
flush_input  input  1  misprediction flush; clears all rename state
from_decoder_write_enabled  input  1  rename request
from_decoder_reg_id  input  REG_ADDR_W  destination register being renamed
from_decoder_rob_id  input  ROB_ID_W  ROB tag allocated to that destination
from_rob_write_enabled  input  1  commit request
from_rob_reg_id  input  REG_ADDR_W  committed destination register
from_rob_rob_id  input  ROB_ID_W  tag of committing entry
from_rob_data  input  XLEN  committed value
rs1_id  input  REG_ADDR_W  read port 1 index
rs2_id  input  REG_ADDR_W  read port 2 index
rs1_busy  output  1  port 1 register awaiting a ROB result
rs1_tag  output  ROB_ID_W  port 1 producer tag (valid when rs1_busy)
rs1_data  output  XLEN  port 1 value (valid when !rs1_busy)
rs2_busy / rs2_tag / rs2_data  output  1 / ROB_ID_W / XLEN  same as port 1, for rs2_id
busy_count  output  REG_ADDR_W+1  number of registers with busy set

Behaviour:
- State per register: data[XLEN], busy, tag[ROB_ID_W]. All updates occur on posedge clk_in.
- Reset, with priority over everything:
  - all data, busy and tag cleared to 0;
  - busy_count = 0;
  - read outputs therefore read 0/0/0.
- Register 0 and any index >= REG_COUNT:
  - rename and commit to these indices are ignored;
  - reads return busy=0, tag=0, data=0.
- Commit, when from_rob_write_enabled:
  - data[reg] <= from_rob_data unconditionally.
  - busy[reg] is cleared only if busy[reg]=1, tag[reg]==from_rob_rob_id, and no same-cycle rename targets the same reg.
  - On a tag mismatch busy and tag are unchanged, because a younger producer owns the register.
- Rename, when from_decoder_write_enabled and no flush:
  - busy[reg] <= 1, tag[reg] <= from_decoder_rob_id.
  - When rename and commit target the same reg in the same cycle, rename wins for busy/tag; the commit still writes data.
- Flush:
  - all busy <= 0, tags <= 0;
  - data preserved;
  - a same-cycle commit still writes data;
  - a same-cycle rename is dropped;
  - busy_count <= 0 next cycle.
- Reads are combinational, with zero-latency commit bypass:
  - If commit is active this cycle, rsN_id==from_rob_reg_id (nonzero, in range), busy set and tag==from_rob_rob_id: output busy=0, data=from_rob_data.
  - Otherwise output the stored busy/tag/data.
  - Reads never reflect a same-cycle rename; the reading instruction sees the state before its own rename.
  - Both ports are independent and may use the same index.
- busy_count:
  - Registered; equals the popcount of busy after each edge.
  - Net change per cycle is +1 for a rename of a non-busy reg, and -1 for a qualifying commit clear.
  - Rename of an already-busy reg gives 0 change; rename plus clear on the same reg gives 0 change.

Test Plan:
- Reset then read rs1=5, rs2=0 -> both busy=0, data=0, busy_count=0.
- Rename r3->tag 0; next cycle read r3 -> busy=1, tag=0, busy_count=1. Commit r3/tag 0/0xDEADBEEF the same cycle as reading r3 -> bypass gives busy=0, data=0xDEADBEEF. Next cycle stored value matches, busy_count=0.
- Rename r7->tag 2, then r7->tag 5. Commit r7/tag 2/0x11 -> data=0x11, busy stays 1, tag=5, busy_count=1. Commit tag 5/0x22 -> busy=0, data=0x22.
- Same-cycle rename r4->tag 9 and commit r4/tag 1 (r4 busy with tag 1) -> next cycle busy=1, tag=9, data=commit value, busy_count unchanged.
- Rename r1, r2, r3 (count=3). Then flush with same-cycle commit r2/tag match/0x55 and rename r6 -> all busy=0, r2 data=0x55, r6 not busy, busy_count=0.
- Rename and commit to r0 -> r0 reads 0, not busy, busy_count=0. Assert rst_in mid-sequence with 4 busy regs -> all state 0 after one edge.
